// File: rtl/bus85_memctl.sv
// bus85_memctl: 8085 multiplexed-bus memory/IO slave with programmable wait states.
// Ports: clk, rst (async, active high); 8085 bus addrdata/addr/ale/iom_/rd_/wr_;
//        ready (0 = wait state), err (sticky strobe conflict);
//        io_in, io_out, io_wr (IO port, active only with BUS85_IOPORT_EN defined).
module bus85_memctl #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 16,
    parameter int MEMBITS  = 10,
    parameter int WAITCNT  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    inout  wire  [DATASIZE-1:0]          addrdata,
    input  logic [ADDRSIZE-DATASIZE-1:0] addr,
    input  logic                         ale,
    input  logic                         iom_,
    input  logic                         rd_,
    input  logic                         wr_,
    output logic                         ready,
    output logic                         err,
    input  logic [DATASIZE-1:0]          io_in,
    output logic [DATASIZE-1:0]          io_out,
    output logic                         io_wr
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS
    } state_t;

    localparam logic [3:0] WLOAD = (WAITCNT > 0) ? 4'(WAITCNT - 1) : 4'd0;

    state_t              state, state_nx;
    logic [3:0]          cnt, cnt_nx;
    logic [ADDRSIZE-1:0] adr_q;
    logic                iom_q;
    logic [MEMBITS-1:0]  idx_q;
    logic                io_q;
    logic                is_wr_q;
    logic [DATASIZE-1:0] rdat_q;
    logic [DATASIZE-1:0] wdat_q;
    logic [DATASIZE-1:0] io_rd;
    logic [DATASIZE-1:0] mem [0:(1<<MEMBITS)-1];

    logic both, any, enter, commit, err_set;
    logic unused_adr;

    assign both  = ~rd_ & ~wr_;
    assign any   = ~rd_ | ~wr_;
    assign enter = (state_nx == ACCESS) && (state != ACCESS);
    assign ready = (state != WAIT);

    // Upper address bits are ignored: the RAM mirrors across the space.
    assign unused_adr = ^adr_q[ADDRSIZE-1:MEMBITS];

    // Drive only during the data phase of a clean read.
    assign addrdata = (state == ACCESS && !rd_ && wr_) ? rdat_q : 'z;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        err_set  = 1'b0;
        commit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (both) begin
                    err_set = 1'b1;
                end else if (any) begin
                    if (WAITCNT > 0) begin
                        state_nx = WAIT;
                        cnt_nx   = WLOAD;
                    end else begin
                        state_nx = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (both) begin
                    err_set  = 1'b1;
                    state_nx = IDLE;
                end else if (cnt == 4'd0) begin
                    state_nx = ACCESS;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ACCESS: begin
                if (both) begin
                    err_set  = 1'b1;
                    state_nx = IDLE;
                end else if (rd_ && wr_) begin
                    commit   = is_wr_q;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            adr_q   <= '0;
            iom_q   <= 1'b0;
            idx_q   <= '0;
            io_q    <= 1'b0;
            is_wr_q <= 1'b0;
            rdat_q  <= '0;
            wdat_q  <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (ale) begin
                adr_q <= {addr, addrdata};
                iom_q <= iom_;
            end
            if (err_set)
                err <= 1'b1;
            if (state == IDLE && any)
                is_wr_q <= ~wr_;
            // Index and target are frozen at entry so a new ALE mid-access
            // cannot redirect the transfer.
            if (enter) begin
                idx_q  <= adr_q[MEMBITS-1:0];
                io_q   <= iom_q;
                rdat_q <= iom_q ? io_rd : mem[adr_q[MEMBITS-1:0]];
            end
            if (!wr_)
                wdat_q <= addrdata;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && !io_q)
            mem[idx_q] <= wdat_q;
    end

`ifdef BUS85_IOPORT_EN
    assign io_rd = io_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_out <= '0;
            io_wr  <= 1'b0;
        end else begin
            io_wr <= commit & io_q;
            if (commit && io_q)
                io_out <= wdat_q;
        end
    end
`else
    logic unused_io;

    assign unused_io = ^io_in;
    assign io_rd     = '1;
    assign io_out    = '0;
    assign io_wr     = 1'b0;
`endif

endmodule
